inst_loader: RTL

- Upstream feeder for the instruction fetch stage.
- Consumes a byte stream from the UART receiver and runs a command FSM.
- Assembles 4 bytes into instruction words and writes them into fetch-stage instruction memory through the write/instruction/address lines.
- After loading, grants execution enable, either continuously (run) or one cycle at a time (step), until the pipeline reports halt.

---
 rtl/inst_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: UART-fed program loader and execution gate for the fetch stage.
// Assembles MSB-first bytes into instruction words and writes them to the
// instruction memory. After a program is loaded, it grants execution enable
// either continuously (run) or for one cycle at a time (step).
module inst_loader #(
  parameter int                   INST_SZ   = 32,
  parameter int                   PC_SZ     = 32,
  parameter int                   BYTE_SZ   = 8,
  parameter int                   MEM_DEPTH = 64,
  parameter logic [INST_SZ-1:0]   HALT_INST = '1,
  parameter logic [BYTE_SZ-1:0]   CMD_LOAD  = 8'h4C,
  parameter logic [BYTE_SZ-1:0]   CMD_RUN   = 8'h52,
  parameter logic [BYTE_SZ-1:0]   CMD_STEP  = 8'h53
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_halt,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [PC_SZ-1:0]   o_inst_addr,
  output logic               o_write,
  output logic               o_enable,
  output logic               o_prog_loaded,
  output logic               o_loading,
  output logic               o_done,
  output logic [PC_SZ-1:0]   o_word_count
);

  localparam int BYTES = INST_SZ / BYTE_SZ;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [PC_SZ-1:0] LAST_SLOT = PC_SZ'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STEP,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [INST_SZ-1:0] shift_q, shift_d;
  logic [PC_SZ-1:0]   wc_q, wc_d;
  logic [INST_SZ-1:0] instr_q, instr_d;
  logic [PC_SZ-1:0]   addr_q, addr_d;
  logic               write_q, write_d;
  logic               enable_q, enable_d;
  logic               loaded_q, loaded_d;
  logic               exit_q, exit_d;
  logic [INST_SZ-1:0] word_w;

  // Word formed if the current byte completes it (earlier bytes in upper bits).
  assign word_w = {shift_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      wc_q     <= '0;
      instr_q  <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      enable_q <= 1'b0;
      loaded_q <= 1'b0;
      exit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      wc_q     <= wc_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      enable_q <= enable_d;
      loaded_q <= loaded_d;
      exit_q   <= exit_d;
    end
  end

  // Command FSM: next state plus next values of every registered output.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    wc_d     = wc_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    write_d  = 1'b0;
    enable_d = enable_q;
    loaded_d = loaded_q;
    exit_d   = exit_q;
    case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d  = S_LOAD;
            wc_d     = '0;
            idx_d    = '0;
            loaded_d = 1'b0;
          end else if (i_rx_data == CMD_RUN && loaded_q) begin
            state_d  = S_RUN;
            enable_d = 1'b1;
          end else if (i_rx_data == CMD_STEP && loaded_q) begin
            state_d  = S_STEP;
            enable_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // The final write is flagged when its word is assembled, but LOAD is
        // held through the write cycle so o_write never appears outside LOAD.
        if (write_q && exit_q) begin
          state_d  = S_IDLE;
          loaded_d = 1'b1;
          exit_d   = 1'b0;
          idx_d    = '0;
        end else if (i_rx_valid) begin
          shift_d = word_w;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            write_d = 1'b1;
            instr_d = word_w;
            addr_d  = {wc_q[PC_SZ-3:0], 2'b00};
            wc_d    = wc_q + PC_SZ'(1);
            exit_d  = (word_w == HALT_INST) || (wc_q == LAST_SLOT);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (i_halt) begin
          enable_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_STEP: begin
        enable_d = 1'b0;
        state_d  = i_halt ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (i_rx_valid && i_rx_data == CMD_LOAD) begin
          state_d  = S_LOAD;
          wc_d     = '0;
          idx_d    = '0;
          loaded_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_instruction = instr_q;
  assign o_inst_addr   = addr_q;
  assign o_write       = write_q;
  assign o_enable      = enable_q;
  assign o_prog_loaded = loaded_q;
  assign o_loading     = (state_q == S_LOAD);
  assign o_done        = (state_q == S_DONE);
  assign o_word_count  = wc_q;

endmodule
